// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock, start/done handshake,
// registered quotient/remainder with divide-by-zero and signed-overflow flags.
module seq_restoring_divider #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero,
  output logic             overflow,
  output logic [1:0]       dbgState
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [1:0] ZERO = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accA;
  logic [WIDTH-1:0] accQ;
  logic [WIDTH-1:0] magD;
  logic             negQ;
  logic             negR;
  logic             ovfPend;

  logic             dvdNeg;
  logic             dsrNeg;
  logic [WIDTH-1:0] absDvd;
  logic [WIDTH-1:0] absDsr;
  logic [WIDTH:0]   shifted;
  logic             trialOk;

  // Handshake: start is taken on any edge where busy is low (state IDLE); done pulses
  // for one cycle on the edge that drops busy, and results/flags hold until the next done.
  assign dvdNeg  = (SIGNED != 0) && dividend[WIDTH-1];
  assign dsrNeg  = (SIGNED != 0) && divisor[WIDTH-1];
  assign absDvd  = dvdNeg ? -dividend : dividend;
  assign absDsr  = dsrNeg ? -divisor : divisor;
  assign shifted = {accA, accQ[WIDTH-1]};
  assign trialOk = shifted >= {1'b0, magD};
  assign dbgState = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      accA      <= '0;
      accQ      <= '0;
      magD      <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      ovfPend   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            negQ    <= dvdNeg ^ dsrNeg;
            negR    <= dvdNeg;
            ovfPend <= (SIGNED != 0) && (dividend == MIN_INT) && (divisor == '1);
            if (divisor == '0) begin
              // The raw dividend rides in accQ so ZERO can return it as the remainder.
              accQ  <= dividend;
              state <= ZERO;
            end else begin
              count <= CW'(WIDTH);
              accA  <= '0;
              accQ  <= absDvd;
              magD  <= absDsr;
              state <= DIV;
            end
          end
        end
        DIV: begin
          accQ  <= {accQ[WIDTH-2:0], trialOk};
          accA  <= trialOk ? WIDTH'(shifted - {1'b0, magD}) : shifted[WIDTH-1:0];
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIN;
        end
        FIN: begin
          // MIN_INT / -1 falls out as MIN_INT rem 0 from the magnitude path; only the flag is extra.
          quotient  <= negQ ? -accQ : accQ;
          remainder <= negR ? -accA : accA;
          overflow  <= ovfPend;
          divByZero <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        ZERO: begin
          quotient  <= '1;
          remainder <= accQ;
          divByZero <= 1'b1;
          overflow  <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: a signed and an unsigned instance share stimulus and
// are checked every cycle against an arithmetic model plus hand-computed literal results.
module tb_seq_restoring_divider;

  localparam int W = 32;

  typedef struct {
    int             acceptCyc;
    int             doneCyc;
    logic [W-1:0]   qS;
    logic [W-1:0]   rS;
    logic [W-1:0]   qU;
    logic [W-1:0]   rU;
    logic           dz;
    logic           ovS;
    logic           ovU;
  } txn_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;

  logic         busyS, doneS, dzS, ovS;
  logic [W-1:0] qS, rS;
  logic [1:0]   stS;
  logic         busyU, doneU, dzU, ovU;
  logic [W-1:0] qU, rU;
  logic [1:0]   stU;

  int   cyc = 0;
  int   nCmp = 0;
  int   nBad = 0;
  txn_t expQ[$];
  txn_t held;

  seq_restoring_divider #(.WIDTH(W), .SIGNED(1)) uSigned (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busyS), .done(doneS), .quotient(qS), .remainder(rS),
    .divByZero(dzS), .overflow(ovS), .dbgState(stS)
  );

  seq_restoring_divider #(.WIDTH(W), .SIGNED(0)) uUnsigned (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busyU), .done(doneU), .quotient(qU), .remainder(rU),
    .divByZero(dzU), .overflow(ovU), .dbgState(stU)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Results straight from integer arithmetic; truncating division gives the signed rules.
  function automatic txn_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    txn_t   t;
    longint sa;
    longint sb;
    t = '{default: '0};
    if (b == '0) begin
      t.qS = '1; t.rS = a; t.qU = '1; t.rU = a; t.dz = 1'b1;
    end else begin
      t.qU = a / b;
      t.rU = a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        t.qS = 32'h8000_0000; t.rS = '0; t.ovS = 1'b1;
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t.qS = W'(sa / sb);
        t.rS = W'(sa % sb);
      end
    end
    return t;
  endfunction

  // Per-cycle compare against the model's timeline and held results.
  always @(posedge clk) begin
    logic expBusy;
    logic expDone;
    cyc++;
    #1;
    expBusy = 1'b0;
    expDone = 1'b0;
    if (expQ.size() > 0) begin
      if (cyc >= expQ[0].acceptCyc && cyc < expQ[0].doneCyc) expBusy = 1'b1;
      if (cyc == expQ[0].doneCyc) begin
        expDone = 1'b1;
        held = expQ.pop_front();
      end
    end
    chk("busyS", W'(busyS), W'(expBusy));
    chk("busyU", W'(busyU), W'(expBusy));
    chk("doneS", W'(doneS), W'(expDone));
    chk("doneU", W'(doneU), W'(expDone));
    chk("qS", qS, held.qS);
    chk("rS", rS, held.rS);
    chk("qU", qU, held.qU);
    chk("rU", rU, held.rU);
    chk("dzS", W'(dzS), W'(held.dz));
    chk("dzU", W'(dzU), W'(held.dz));
    chk("ovS", W'(ovS), W'(held.ovS));
    chk("ovU", W'(ovU), W'(held.ovU));
  end

  // Called at a negedge; drives one start and books the expected transaction.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    txn_t t;
    int   g;
    g = 0;
    while (expQ.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("issue_wait", W'(g), W'(0));
    t = model(a, b);
    t.acceptCyc = cyc + 1;
    t.doneCyc   = cyc + 1 + ((b == '0) ? 1 : W + 1);
    expQ.push_back(t);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Returns at the negedge of the expected done cycle.
  task automatic waitDone();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("done_wait", W'(g), W'(0));
  endtask

  task automatic poke(input int after);
    repeat (after) @(negedge clk);
    start    = 1'b1;
    dividend = $urandom;
    divisor  = $urandom;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic chkZeroOutputs(input string tag);
    chk({tag, "_busy"}, W'({busyS, busyU}), '0);
    chk({tag, "_done"}, W'({doneS, doneU}), '0);
    chk({tag, "_q"}, qS | qU, '0);
    chk({tag, "_r"}, rS | rU, '0);
    chk({tag, "_flags"}, W'({dzS, dzU, ovS, ovU}), '0);
    chk({tag, "_state"}, W'({stS, stU}), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", nCmp, nBad);
    $fatal(1);
  end

  initial begin
    int n;
    int busyCnt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    held = '{default: '0};
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    chkZeroOutputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // 100 / 7 with explicit latency and busy-length measurement.
    issue(32'd100, 32'd7);
    n = 0;
    busyCnt = 0;
    while (doneS !== 1'b1 && n < 60) begin
      busyCnt += int'(busyS);
      @(negedge clk);
      n++;
    end
    chk("latency", W'(n), W'(33));
    chk("busy_len", W'(busyCnt), W'(33));
    chk("b_q", qS, 32'd14);
    chk("b_r", rS, 32'd2);
    chk("b_flags", W'({dzS, ovS}), '0);

    // Sign combinations back-to-back, each start raised in the previous done cycle.
    issue(-32'sd100, 32'd7);
    waitDone();
    chk("s1_q", qS, 32'hFFFF_FFF2);
    chk("s1_r", rS, 32'hFFFF_FFFE);
    issue(32'd100, -32'sd7);
    waitDone();
    chk("s2_q", qS, 32'hFFFF_FFF2);
    chk("s2_r", rS, 32'd2);
    issue(-32'sd100, -32'sd7);
    waitDone();
    chk("s3_q", qS, 32'd14);
    chk("s3_r", rS, 32'hFFFF_FFFE);

    // Divide by zero, then a valid divide clears the flag.
    issue(32'h1234_5678, 32'd0);
    waitDone();
    chk("z_done", W'(doneS), W'(1));
    chk("z_q", qS, 32'hFFFF_FFFF);
    chk("z_r", rS, 32'h1234_5678);
    chk("z_dz", W'({dzS, dzU}), W'(2'b11));
    issue(32'd1000, 32'd3);
    waitDone();
    chk("zc_dz", W'({dzS, dzU}), '0);
    chk("zc_q", qS, 32'd333);

    // Signed overflow corner; the unsigned instance sees a plain divide.
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    waitDone();
    chk("o_q", qS, 32'h8000_0000);
    chk("o_r", rS, 32'd0);
    chk("o_ov", W'(ovS), W'(1));
    chk("o_qu", qU, 32'd0);
    chk("o_ru", rU, 32'h8000_0000);
    chk("o_ovu", W'(ovU), W'(0));

    // Unsigned cases.
    issue(32'hFFFF_FFFF, 32'h10);
    waitDone();
    chk("u1_q", qU, 32'h0FFF_FFFF);
    chk("u1_r", rU, 32'hF);
    chk("u1_qs", qS, 32'd0);
    chk("u1_rs", rS, 32'hFFFF_FFFF);
    issue(32'd5, 32'd9);
    waitDone();
    chk("u2_q", qU, 32'd0);
    chk("u2_r", rU, 32'd5);

    // Randomized operands with idle gaps and ignored starts while busy.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = '1;
        3: begin a = 32'h8000_0000; b = '1; end
        4: b = -W'($urandom_range(1, 300));
        5: begin a = W'($urandom_range(0, 50)); b = W'($urandom_range(1, 60)); end
        default: b = $urandom;
      endcase
      issue(a, b);
      if (b != '0 && $urandom_range(0, 1) == 1) poke($urandom_range(1, 20));
      waitDone();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Start pulse with new operands mid-divide must not disturb the running one.
    issue(32'd1_000_000, 32'd37);
    poke(9);
    waitDone();
    chk("rb_q", qS, 32'd27027);
    chk("rb_r", rS, 32'd1);

    // Reset dropped mid-divide clears everything at once.
    issue(32'd12345, 32'd67);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    held = '{default: '0};
    #1;
    chkZeroOutputs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(32'd81, 32'd9);
    waitDone();
    chk("ar_q", qS, 32'd9);
    chk("ar_r", rS, 32'd0);
    chk("ar_qu", qU, 32'd9);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
